// File: rtl/ff_stream_monitor_pkg.sv
// Shared constants for the op0 stream monitor: tag, pattern FSM encoding and reference pattern.
package ff_stream_monitor_pkg;

    localparam logic [19:0] ID_NUM  = 20'h66165;
    localparam logic [3:0]  PATTERN = 4'b1011;

    typedef enum logic [1:0] {
        S0   = 2'd0,
        S1   = 2'd1,
        S10  = 2'd2,
        S101 = 2'd3
    } pat_state_e;

endpackage

// File: rtl/ff_stream_monitor_sat_counter.sv
// Up-counter that stops at MAX instead of wrapping; sat flags the stopped value.
module sat_counter #(
    parameter int unsigned W   = 8,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clk,
    input  logic         clear0,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge clear0) begin
        if (!clear0) begin
            count_q <= '0;
        end else if (inc && (count_q != MAX)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;
    assign sat   = (count_q == MAX);

endmodule

// File: rtl/ff_stream_monitor.sv
// Samples the upstream op0 bitstream on enabled edges and reports history, edges and 1011 matches.
module ff_stream_monitor
    import ff_stream_monitor_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             clear0,
    input  logic             din,
    input  logic             en,
    output logic [WIDTH-1:0] shift_q,
    output logic             fill_valid,
    output logic             rise_pulse,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat,
    output logic [19:0]      id_num
);

    localparam int unsigned FILL_W = $clog2(WIDTH + 1);

    pat_state_e       state_q;
    logic [WIDTH-1:0] shift_r_q;
    logic [FILL_W-1:0] fill_q;
    logic             fill_valid_q;
    logic             prev_q;
    logic             rise_q;
    logic             match_q;
    logic             match_hit;

    // A sample completing 1011 is a 1 arriving while the FSM sits in S101.
    assign match_hit = en && (state_q == S101) && din;

    always_ff @(posedge clk or negedge clear0) begin
        if (!clear0) begin
            state_q      <= S0;
            shift_r_q    <= '0;
            fill_q       <= '0;
            fill_valid_q <= 1'b0;
            prev_q       <= 1'b0;
            rise_q       <= 1'b0;
            match_q      <= 1'b0;
        end else begin
            rise_q  <= 1'b0;
            match_q <= 1'b0;
            if (en) begin
                shift_r_q <= {shift_r_q[WIDTH-2:0], din};
                prev_q    <= din;
                rise_q    <= din & ~prev_q;
                match_q   <= match_hit;
                if (!fill_valid_q) begin
                    fill_q       <= fill_q + FILL_W'(1);
                    fill_valid_q <= (fill_q == FILL_W'(WIDTH - 1));
                end
                unique case (state_q)
                    S0:      state_q <= din ? S1   : S0;
                    S1:      state_q <= din ? S1   : S10;
                    S10:     state_q <= din ? S101 : S0;
                    S101:    state_q <= din ? S1   : S10;
                    default: state_q <= S0;
                endcase
            end
        end
    end

    sat_counter #(
        .W  (CNT_W),
        .MAX({CNT_W{1'b1}})
    ) u_match_cnt (
        .clk   (clk),
        .clear0(clear0),
        .inc   (match_hit),
        .count (match_count),
        .sat   (count_sat)
    );

    assign shift_q    = shift_r_q;
    assign fill_valid = fill_valid_q;
    assign rise_pulse = rise_q;
    assign match      = match_q;
    assign id_num     = ID_NUM;

endmodule

// File: tb/tb_ff_stream_monitor.sv
// Scoreboard bench for ff_stream_monitor (WIDTH=8, CNT_W=4 so saturation is reachable).
module tb_ff_stream_monitor;
    import ff_stream_monitor_pkg::*;

    typedef struct packed {
        logic [7:0] sh;
        logic       fv;
        logic       rp;
        logic       m;
        logic [3:0] cnt;
        logic       sat;
    } obs_t;

    logic       clk = 1'b0;
    logic       clear0;
    logic       din;
    logic       en;
    logic [7:0] shift_q;
    logic       fill_valid, rise_pulse, match, count_sat;
    logic [3:0] match_count;
    logic [19:0] id_num;

    int vec    = 0;
    int miscmp = 0;

    obs_t sb[$];

    logic [7:0] m_sh;
    logic [3:0] m_last4;
    logic       m_prev;
    int         m_fill;
    int         m_cnt;

    ff_stream_monitor #(.WIDTH(8), .CNT_W(4)) dut (
        .clk        (clk),
        .clear0     (clear0),
        .din        (din),
        .en         (en),
        .shift_q    (shift_q),
        .fill_valid (fill_valid),
        .rise_pulse (rise_pulse),
        .match      (match),
        .match_count(match_count),
        .count_sat  (count_sat),
        .id_num     (id_num)
    );

    always #5 clk = ~clk;

    function automatic obs_t cur();
        return {shift_q, fill_valid, rise_pulse, match, match_count, count_sat};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("sh=%h fv=%b rp=%b m=%b cnt=%0d sat=%b", o.sh, o.fv, o.rp, o.m, o.cnt, o.sat);
    endfunction

    task automatic model_reset();
        m_sh = '0; m_last4 = '0; m_prev = 1'b0; m_fill = 0; m_cnt = 0;
        sb.delete();
    endtask

    // Drive one cycle, then push the model's expectation for the post-edge outputs.
    task automatic drive(input logic e, input logic d);
        obs_t x;
        logic r, mt;
        en = e; din = d;
        @(posedge clk);
        #1;
        r = 1'b0; mt = 1'b0;
        if (e) begin
            m_sh    = {m_sh[6:0], d};
            m_last4 = {m_last4[2:0], d};
            r       = d & ~m_prev;
            m_prev  = d;
            if (m_fill < 8) m_fill++;
            mt = (m_last4 == PATTERN);
            if (mt && m_cnt < 15) m_cnt++;
        end
        x = {m_sh, (m_fill == 8), r, mt, 4'(m_cnt), (m_cnt == 15)};
        sb.push_back(x);
    endtask

    task automatic apply_reset();
        clear0 = 1'b0; en = 1'b0; din = 1'b0;
        @(posedge clk);
        #2;
        clear0 = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        obs_t got, want;
        clear0 = 1'b0; en = 1'b1; din = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        got = cur(); want = '0; vec++;
        if (got !== want) begin miscmp++; $display("FAIL reset_hold: got %s want %s", fmt(got), fmt(want)); end
        vec++;
        if (id_num !== 20'h66165) begin miscmp++; $display("FAIL id_num: got %h want 66165", id_num); end
        #2 clear0 = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1);
            want = sb.pop_front(); got = cur(); vec++;
            if (got !== want) begin miscmp++; $display("FAIL reset_pre[%0d]: got %s want %s", i, fmt(got), fmt(want)); end
        end
        #2 clear0 = 1'b0;
        #1;
        got = cur(); want = '0; vec++;
        if (got !== want) begin miscmp++; $display("FAIL reset_async: got %s want %s", fmt(got), fmt(want)); end
        vec++;
        if (id_num !== 20'h66165) begin miscmp++; $display("FAIL id_in_reset: got %h want 66165", id_num); end
        @(posedge clk);
        #2 clear0 = 1'b1;
        model_reset();
    endtask

    task automatic test_fill();
        logic [7:0] pat = 8'b1011_0010;
        obs_t got, want;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, pat[7-i]);
            want = sb.pop_front(); got = cur(); vec++;
            if (got !== want) begin miscmp++; $display("FAIL fill[%0d]: got %s want %s", i, fmt(got), fmt(want)); end
            if (i == 6) begin
                vec++;
                if (fill_valid !== 1'b0) begin miscmp++; $display("FAIL fill_early: got %b want 0", fill_valid); end
            end
        end
        vec++;
        if (shift_q !== 8'hB2 || fill_valid !== 1'b1 || match_count !== 4'd1) begin
            miscmp++;
            $display("FAIL fill_final: got sh=%h fv=%b cnt=%0d want sh=b2 fv=1 cnt=1", shift_q, fill_valid, match_count);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] pat = 7'b1011011;
        logic [6:0] rp_seen, m_seen;
        obs_t got, want;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, pat[6-i]);
            want = sb.pop_front(); got = cur(); vec++;
            rp_seen[i] = rise_pulse; m_seen[i] = match;
            if (got !== want) begin miscmp++; $display("FAIL overlap[%0d]: got %s want %s", i, fmt(got), fmt(want)); end
        end
        vec++;
        if (m_seen !== 7'b1001000 || rp_seen !== 7'b0100101 || match_count !== 4'd2) begin
            miscmp++;
            $display("FAIL overlap_pulses: got m=%b rp=%b cnt=%0d want m=1001000 rp=0100101 cnt=2", m_seen, rp_seen, match_count);
        end
    endtask

    task automatic test_enable_gating();
        logic [2:0] pat = 3'b101;
        obs_t got, want;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pat[2-i]);
            want = sb.pop_front(); got = cur(); vec++;
            if (got !== want) begin miscmp++; $display("FAIL gate_pre[%0d]: got %s want %s", i, fmt(got), fmt(want)); end
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0);
            want = sb.pop_front(); got = cur(); vec++;
            if (got !== want || rise_pulse !== 1'b0 || match !== 1'b0) begin
                miscmp++; $display("FAIL gate_hold[%0d]: got %s want %s", i, fmt(got), fmt(want));
            end
        end
        drive(1'b1, 1'b1);
        want = sb.pop_front(); got = cur(); vec++;
        if (got !== want || match !== 1'b1) begin miscmp++; $display("FAIL gate_resume: got %s want %s", fmt(got), fmt(want)); end
    endtask

    task automatic test_saturation();
        logic [3:0] grp = PATTERN;
        obs_t got, want;
        apply_reset();
        for (int g = 0; g < 16; g++) begin
            for (int b = 0; b < 4; b++) begin
                drive(1'b1, grp[3-b]);
                want = sb.pop_front(); got = cur(); vec++;
                if (got !== want) begin miscmp++; $display("FAIL sat[%0d.%0d]: got %s want %s", g, b, fmt(got), fmt(want)); end
            end
        end
        vec++;
        if (match !== 1'b1 || match_count !== 4'd15 || count_sat !== 1'b1) begin
            miscmp++; $display("FAIL sat_final: got m=%b cnt=%0d sat=%b want m=1 cnt=15 sat=1", match, match_count, count_sat);
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] pre  = 3'b101;
        logic [2:0] post = 3'b011;
        obs_t got, want;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pre[2-i]);
            want = sb.pop_front(); got = cur(); vec++;
            if (got !== want) begin miscmp++; $display("FAIL mid_pre[%0d]: got %s want %s", i, fmt(got), fmt(want)); end
        end
        apply_reset();
        drive(1'b1, 1'b1);
        want = sb.pop_front(); got = cur(); vec++;
        if (got !== want || match !== 1'b0) begin miscmp++; $display("FAIL mid_single1: got %s want %s", fmt(got), fmt(want)); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, post[2-i]);
            want = sb.pop_front(); got = cur(); vec++;
            if (got !== want) begin miscmp++; $display("FAIL mid_post[%0d]: got %s want %s", i, fmt(got), fmt(want)); end
        end
        vec++;
        if (match !== 1'b1 || match_count !== 4'd1) begin
            miscmp++; $display("FAIL mid_final: got m=%b cnt=%0d want m=1 cnt=1", match, match_count);
        end
    endtask

    initial begin
        clear0 = 1'b0; en = 1'b0; din = 1'b0;
        model_reset();
        test_reset();
        test_fill();
        test_overlap();
        test_enable_gating();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
